branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/multicore_pkg.sv | 7 +
 rtl/branch_resolve.sv | 146 ++++++++++++++
 tb/tb_branch_resolve.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicore_pkg.sv
// Shared constants for the multicore pipeline.
package multicore_pkg;

   // Width of data words and addresses across the core.
   localparam int DATA_SIZE = 32;

endpackage

// File: rtl/branch_resolve.sv
// Branch/jump resolution: computes the actual direction and target of a
// control-flow instruction, redirects fetch on a mispredict, squashes
// younger instructions for a fixed number of cycles, and produces the
// link value for JAL/JALR writeback.
module branch_resolve
   import multicore_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [1:0]           i_kind,
   input  logic                 i_taken,
   input  logic                 i_pred_taken,
   input  logic [DATA_SIZE-1:0] i_pc,
   input  logic [DATA_SIZE-1:0] i_imm,
   input  logic [DATA_SIZE-1:0] i_rs1,
   output logic                 o_redirect_valid,
   input  logic                 i_redirect_ready,
   output logic [DATA_SIZE-1:0] o_redirect_pc,
   output logic                 o_flush,
   output logic                 o_link_valid,
   output logic [DATA_SIZE-1:0] o_link,
   output logic [15:0]          o_mispredict_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      REDIRECT,
      FLUSH
   } state_t;

   localparam logic [1:0] KIND_BRANCH = 2'b00;
   localparam logic [1:0] KIND_JAL    = 2'b01;
   localparam logic [1:0] KIND_JALR   = 2'b10;
   localparam logic [1:0] KIND_RSVD   = 2'b11;

   state_t               state_q, state_d;
   logic [3:0]           flush_cnt_q, flush_cnt_d;
   logic [DATA_SIZE-1:0] redirect_pc_q, redirect_pc_d;
   logic [DATA_SIZE-1:0] link_q, link_d;
   logic                 link_valid_q, link_valid_d;
   logic [15:0]          cnt_q, cnt_d;

   logic                 accept;
   logic                 is_jump;
   logic                 actual_taken;
   logic                 mispredict;
   logic [DATA_SIZE-1:0] jalr_sum;
   logic [DATA_SIZE-1:0] target;
   logic [DATA_SIZE-1:0] fall_through;

   // Decode the request: direction, target and whether fetch guessed wrong.
   // Reserved kinds are never accepted, so they leave every output untouched.
   assign accept       = i_valid && (state_q == IDLE) && (i_kind != KIND_RSVD);
   assign is_jump      = (i_kind == KIND_JAL) || (i_kind == KIND_JALR);
   assign actual_taken = (i_kind == KIND_BRANCH) ? i_taken : 1'b1;
   assign jalr_sum     = i_rs1 + i_imm;
   assign target       = (i_kind == KIND_JALR) ? {jalr_sum[DATA_SIZE-1:1], 1'b0}
                                               : i_pc + i_imm;
   assign fall_through = i_pc + DATA_SIZE'(4);
   // JALR targets are register-based and never predicted, so always redirect.
   assign mispredict   = (actual_taken != i_pred_taken) || (i_kind == KIND_JALR);

   // Next-state logic for the redirect/flush sequence, link pulse and counter.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned; that is what keeps this block from inferring latches.
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      redirect_pc_d = redirect_pc_q;
      link_d        = link_q;
      link_valid_d  = 1'b0;
      cnt_d         = cnt_q;
      o_flush       = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_jump) begin
                  link_valid_d = 1'b1;
                  link_d       = fall_through;
               end
               if (mispredict) begin
                  state_d       = REDIRECT;
                  redirect_pc_d = actual_taken ? target : fall_through;
               end
            end
         end
         REDIRECT: begin
            // The handshake cycle already squashes, then FLUSH adds more cycles.
            if (i_redirect_ready) begin
               o_flush     = 1'b1;
               state_d     = FLUSH;
               flush_cnt_d = 4'(FLUSH_CYCLES);
               if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         FLUSH: begin
            o_flush = 1'b1;
            if (flush_cnt_q <= 4'd1) begin
               state_d     = IDLE;
               flush_cnt_d = 4'd0;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset is asynchronous so a flush can be aborted mid-cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (i_rst) begin
         state_q       <= IDLE;
         flush_cnt_q   <= 4'd0;
         redirect_pc_q <= '0;
         link_q        <= '0;
         link_valid_q  <= 1'b0;
         cnt_q         <= 16'd0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         redirect_pc_q <= redirect_pc_d;
         link_q        <= link_d;
         link_valid_q  <= link_valid_d;
         cnt_q         <= cnt_d;
      end
   end

   assign o_ready          = (state_q == IDLE);
   assign o_redirect_valid = (state_q == REDIRECT);
   assign o_redirect_pc    = redirect_pc_q;
   assign o_link_valid     = link_valid_q;
   assign o_link           = link_q;
   assign o_mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model.
module tb_branch_resolve;
   import multicore_pkg::*;

   localparam int FLUSH = 2;

   logic                 clk;
   logic                 rst;
   logic                 valid;
   logic                 ready;
   logic [1:0]           kind;
   logic                 taken;
   logic                 pred;
   logic [DATA_SIZE-1:0] pc;
   logic [DATA_SIZE-1:0] imm;
   logic [DATA_SIZE-1:0] rs1;
   logic                 rv;
   logic                 rr;
   logic [DATA_SIZE-1:0] rpc;
   logic                 flush;
   logic                 lv;
   logic [DATA_SIZE-1:0] link;
   logic [15:0]          cnt;

   int total = 0;
   int bad   = 0;

   branch_resolve #(.FLUSH_CYCLES(FLUSH)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_valid          (valid),
      .o_ready          (ready),
      .i_kind           (kind),
      .i_taken          (taken),
      .i_pred_taken     (pred),
      .i_pc             (pc),
      .i_imm            (imm),
      .i_rs1            (rs1),
      .o_redirect_valid (rv),
      .i_redirect_ready (rr),
      .o_redirect_pc    (rpc),
      .o_flush          (flush),
      .o_link_valid     (lv),
      .o_link           (link),
      .o_mispredict_cnt (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A pending redirect waits for fetch; once taken, fetch is squashed for
   // the handshake cycle plus FLUSH more cycles. Link pulses one cycle after
   // any accepted jump.
   logic        m_pend;
   logic [31:0] m_rpc;
   int          m_fl;
   logic        m_lv;
   logic [31:0] m_link;
   logic [15:0] m_cnt;

   initial begin
      m_pend = 0; m_rpc = 0; m_fl = 0; m_lv = 0; m_link = 0; m_cnt = 0;
   end

   always @(negedge clk) begin
      logic        act_t;
      logic [31:0] tgt;
      logic [31:0] sum;
      if (rst) begin
         check("rst_ready", 32'(ready), 32'd1);
         check("rst_rv",    32'(rv),    32'd0);
         check("rst_flush", 32'(flush), 32'd0);
         check("rst_lv",    32'(lv),    32'd0);
         check("rst_rpc",   rpc,        32'd0);
         check("rst_link",  link,       32'd0);
         check("rst_cnt",   32'(cnt),   32'd0);
         m_pend = 0; m_rpc = 0; m_fl = 0; m_lv = 0; m_link = 0; m_cnt = 0;
      end else begin
         check("ready", 32'(ready), 32'(!m_pend && m_fl == 0));
         check("rv",    32'(rv),    32'(m_pend));
         if (m_pend) check("rpc", rpc, m_rpc);
         check("flush", 32'(flush), 32'((m_pend && rr) || m_fl > 0));
         check("lv",    32'(lv),    32'(m_lv));
         if (m_lv) check("link", link, m_link);
         check("cnt",   32'(cnt),   32'(m_cnt));
         // advance the model to the coming rising edge
         m_lv = 0;
         if (m_pend) begin
            if (rr) begin
               m_pend = 0;
               m_fl   = FLUSH;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end
         end else if (m_fl > 0) begin
            m_fl = m_fl - 1;
         end else if (valid && kind != 2'b11) begin
            act_t = (kind == 2'b00) ? taken : 1'b1;
            sum   = rs1 + imm;
            tgt   = (kind == 2'b10) ? (sum & 32'hFFFF_FFFE) : (pc + imm);
            if (kind != 2'b00) begin
               m_lv   = 1;
               m_link = pc + 4;
            end
            if (act_t != pred || kind == 2'b10) begin
               m_pend = 1;
               m_rpc  = act_t ? tgt : pc + 4;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] k, input logic t, input logic p,
                      input logic [31:0] a, input logic [31:0] i, input logic [31:0] r);
      valid = 1; kind = k; taken = t; pred = p; pc = a; imm = i; rs1 = r;
   endtask

   initial begin
      rst = 1; valid = 0; kind = 0; taken = 0; pred = 0;
      pc = 0; imm = 0; rs1 = 0; rr = 0;
      #2;
      check("init_ready", 32'(ready), 32'd1);
      check("init_rv",    32'(rv),    32'd0);
      check("init_cnt",   32'(cnt),   32'd0);
      cyc();
      rst = 0;
      cyc();
      check("post_rst_ready", 32'(ready), 32'd1);

      // taken branch predicted not-taken, fetch ready at once
      req(2'b00, 1, 0, 32'h100, 32'h20, 32'h0);
      rr = 1;
      cyc();
      valid = 0;
      check("t1_rv",    32'(rv),    32'd1);
      check("t1_rpc",   rpc,        32'h120);
      check("t1_flush0", 32'(flush), 32'd1);
      check("t1_ready", 32'(ready), 32'd0);
      cyc();
      check("t1_flush1", 32'(flush), 32'd1);
      check("t1_rv_off", 32'(rv),   32'd0);
      check("t1_cnt",    32'(cnt),  32'd1);
      cyc();
      check("t1_flush2", 32'(flush), 32'd1);
      cyc();
      check("t1_flush3", 32'(flush), 32'd0);
      check("t1_idle",   32'(ready), 32'd1);

      // not-taken branch predicted taken, fetch stalls for 4 cycles
      req(2'b00, 0, 1, 32'h200, 32'h40, 32'h0);
      rr = 0;
      cyc();
      req(2'b01, 0, 0, 32'h500, 32'h8, 32'h0);   // must be ignored while busy
      for (int n = 0; n < 4; n++) begin
         check("t2_rv",    32'(rv),    32'd1);
         check("t2_rpc",   rpc,        32'h204);
         check("t2_ready", 32'(ready), 32'd0);
         check("t2_flush", 32'(flush), 32'd0);
         check("t2_lv",    32'(lv),    32'd0);
         cyc();
      end
      valid = 0;
      rr = 1;
      #1;
      check("t2_hs_flush", 32'(flush), 32'd1);
      cyc();
      check("t2_cnt", 32'(cnt), 32'd2);
      cyc();
      cyc();
      check("t2_idle", 32'(ready), 32'd1);

      // JALR always redirects, with bit 0 of the target cleared
      req(2'b10, 0, 1, 32'h300, 32'h4, 32'h1001);
      cyc();
      valid = 0;
      check("t3_rv",   32'(rv), 32'd1);
      check("t3_rpc",  rpc,     32'h1004);
      check("t3_lv",   32'(lv), 32'd1);
      check("t3_link", link,    32'h304);
      cyc();
      check("t3_lv_off", 32'(lv), 32'd0);
      cyc();
      cyc();
      check("t3_idle", 32'(ready), 32'd1);
      check("t3_cnt",  32'(cnt),   32'd3);

      // two correctly predicted branches back to back
      req(2'b00, 1, 1, 32'h400, 32'h8, 32'h0);
      cyc();
      check("t4_ready1", 32'(ready), 32'd1);
      check("t4_rv1",    32'(rv),    32'd0);
      req(2'b00, 0, 0, 32'h404, 32'h8, 32'h0);
      cyc();
      valid = 0;
      check("t4_ready2", 32'(ready), 32'd1);
      check("t4_rv2",    32'(rv),    32'd0);
      check("t4_flush",  32'(flush), 32'd0);
      check("t4_cnt",    32'(cnt),   32'd3);

      // reserved kind is ignored even if it looks like a mispredict
      req(2'b11, 1, 0, 32'h600, 32'h10, 32'h0);
      cyc();
      valid = 0;
      check("rsvd_rv",    32'(rv),    32'd0);
      check("rsvd_lv",    32'(lv),    32'd0);
      check("rsvd_ready", 32'(ready), 32'd1);

      // reset in the middle of a flush, without a clock edge
      req(2'b00, 1, 0, 32'h700, 32'h4, 32'h0);
      rr = 1;
      cyc();
      valid = 0;
      cyc();
      check("t5_in_flush", 32'(flush), 32'd1);
      #1;
      rst = 1;
      #1;
      check("t5_flush_drop", 32'(flush), 32'd0);
      check("t5_cnt_clr",    32'(cnt),   32'd0);
      check("t5_ready_rst",  32'(ready), 32'd1);
      #4;
      rst = 0;
      cyc();
      check("t5_ready", 32'(ready), 32'd1);

      // saturation: preload the counter, then one more redirect
      #1;
      force dut.cnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1;
      release dut.cnt_q;
      req(2'b00, 0, 1, 32'h800, 32'h4, 32'h0);
      cyc();
      valid = 0;
      cyc();
      check("t5_sat", 32'(cnt), 32'hFFFF);
      cyc();
      cyc();

      // randomized traffic, occasional resets
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 199) == 0);
         valid = $urandom_range(0, 1) == 1;
         kind  = 2'($urandom_range(0, 3));
         taken = $urandom_range(0, 1) == 1;
         pred  = $urandom_range(0, 1) == 1;
         pc    = $urandom();
         imm   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 64));
         rs1   = $urandom();
         rr    = $urandom_range(0, 2) != 0;
         cyc();
      end
      rst = 0; valid = 0; rr = 1;
      repeat (6) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
